// File: rtl/neuron_pair_mac.sv
// neuron_pair_mac: two-neuron signed dot-product stage fed by the S-step
// address sequencer. Holds x, w0 and w1 locally and returns y0/y1 over a
// valid/ready handshake.
// Optional build macro: RELU_OUT_EN clamps negative results to 0 before they
// are registered into y0/y1. The timing and the handshake are unchanged.
module neuron_pair_mac #(
    parameter int unsigned S     = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = 2*DW+3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_en,
    input  logic [1:0]              load_sel,
    input  logic [AW-1:0]           load_addr,
    input  logic signed [DW-1:0]    load_data,
    input  logic                    start,
    input  logic [AW-1:0]           addr_r,
    input  logic [AW-1:0]           addr_c,
    input  logic                    finished,
    output logic signed [ACC_W-1:0] y0,
    output logic signed [ACC_W-1:0] y1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    sync_err
);

    localparam int unsigned SW = $clog2(S+2);
    localparam int unsigned PW = 2*DW;
    localparam logic [SW-1:0] STEP_FIRST = SW'(1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(S+1);
    localparam logic [AW:0]   ADDR_LIM   = (AW+1)'(S);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           step_q;
    logic signed [DW-1:0]    xr_q;
    logic signed [ACC_W-1:0] acc0_q, acc1_q;

    logic signed [DW-1:0]    x_mem  [S];
    logic signed [DW-1:0]    w0_mem [S];
    logic signed [DW-1:0]    w1_mem [S];

    logic                    last_step;
    logic                    x_win;
    logic                    w_win;
    logic                    load_ok;
    logic signed [PW-1:0]    prod0, prod1;
    logic signed [ACC_W-1:0] sum0, sum1;
    logic signed [ACC_W-1:0] res0, res1;

    // Step windows, product/sum path and optional output clamp
    always_comb begin
        last_step = (step_q == STEP_LAST);
        x_win     = (state_q == RUN) && !last_step;
        w_win     = (state_q == RUN) && (step_q != STEP_FIRST);
        load_ok   = load_en && (state_q == IDLE) && ({1'b0, load_addr} < ADDR_LIM);
        prod0     = PW'(xr_q) * PW'(w0_mem[addr_c]);
        prod1     = PW'(xr_q) * PW'(w1_mem[addr_c]);
        sum0      = acc0_q + ACC_W'(prod0);
        sum1      = acc1_q + ACC_W'(prod1);
`ifdef RELU_OUT_EN
        res0      = sum0[ACC_W-1] ? '0 : sum0;
        res1      = sum1[ACC_W-1] ? '0 : sum1;
`else
        res0      = sum0;
        res1      = sum1;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)                  state_d = RUN;
            RUN:     if (last_step)              state_d = OUT;
            OUT:     if (out_valid && out_ready) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Step counter, x latch, accumulators, results and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q    <= '0;
            xr_q      <= '0;
            acc0_q    <= '0;
            acc1_q    <= '0;
            y0        <= '0;
            y1        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= (state_d == OUT);
            busy      <= (state_d == RUN);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc0_q <= '0;
                        acc1_q <= '0;
                        step_q <= STEP_FIRST;
                    end
                end
                RUN: begin
                    step_q <= last_step ? '0 : step_q + SW'(1);
                    if (x_win) begin
                        xr_q <= x_mem[addr_r];
                    end
                    if (w_win) begin
                        acc0_q <= sum0;
                        acc1_q <= sum1;
                    end
                    if (last_step) begin
                        y0 <= res0;
                        y1 <= res1;
                    end
                    if (finished != last_step) begin
                        sync_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Operand memories: written only while idle and never cleared by reset
    always_ff @(posedge clk) begin
        if (load_ok) begin
            case (load_sel)
                2'd0:    x_mem[load_addr]  <= load_data;
                2'd1:    w0_mem[load_addr] <= load_data;
                2'd2:    w1_mem[load_addr] <= load_data;
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_pair_mac.sv
// Directed bench for neuron_pair_mac: table of operand sets with
// hand-computed dot products, plus sequences for the handshake stall,
// mid-run reset, loads during a run and the lockstep error flag.
module tb_neuron_pair_mac;

    localparam int S     = 8;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int ACC_W = 2*DW+3;

    logic                    clk;
    logic                    reset_n;
    logic                    load_en;
    logic [1:0]              load_sel;
    logic [AW-1:0]           load_addr;
    logic signed [DW-1:0]    load_data;
    logic                    start;
    logic [AW-1:0]           addr_r;
    logic [AW-1:0]           addr_c;
    logic                    finished;
    logic signed [ACC_W-1:0] y0;
    logic signed [ACC_W-1:0] y1;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
    logic                    sync_err;

    neuron_pair_mac #(.S(S), .AW(AW), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .addr_r    (addr_r),
        .addr_c    (addr_c),
        .finished  (finished),
        .y0        (y0),
        .y1        (y1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .sync_err  (sync_err)
    );

    typedef struct packed {
        logic [7:0][7:0] x;
        logic [7:0][7:0] w0;
        logic [7:0][7:0] w1;
        int              e0;
        int              e1;
    } vec_t;

    vec_t vecs [4];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int relu_exp(input int v);
`ifdef RELU_OUT_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic load_word(input logic [1:0] sel, input int addr, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = AW'(addr);
        load_data = d;
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < S; i++) begin
            load_word(2'd0, i, v.x[i]);
            load_word(2'd1, i, v.w0[i]);
            load_word(2'd2, i, v.w1[i]);
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Drive the sequencer view for step k (the next rising edge is edge k)
    task automatic step_drive(input int k, input logic fin, input logic ld);
        @(negedge clk);
        start     = 1'b0;
        addr_r    = (k <= S) ? AW'(k-1) : '0;
        addr_c    = (k >= 2) ? AW'(k-2) : '0;
        finished  = fin;
        load_en   = ld;
        load_sel  = 2'd0;
        load_addr = '0;
        load_data = 8'sd100;
    endtask

    // Start pulse plus S+1 lockstep steps; returns one half-cycle after edge S+1
    task automatic run_to_result(input int fin_at, input int ld_step);
        @(negedge clk);
        start    = 1'b1;
        finished = 1'b0;
        for (int k = 1; k <= S+1; k++) begin
            step_drive(k, (k == S+1) || (k == fin_at), k == ld_step);
            if (k == 2)   chk("busy_in_run", 32'(busy), 1);
            if (k == S+1) chk("valid_early", 32'(out_valid), 0);
        end
        @(negedge clk);
        finished = 1'b0;
        load_en  = 1'b0;
        chk("valid_latency", 32'(out_valid), 1);
        chk("busy_in_out", 32'(busy), 0);
    endtask

    task automatic expect_and_accept(input string tag, input int e0, input int e1,
                                     input int hold);
        chk({tag, "_y0"}, y0, e0);
        chk({tag, "_y1"}, y1, e1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 1);
            chk({tag, "_hold_y0"}, y0, e0);
            chk({tag, "_hold_y1"}, y1, e1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_accept_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        load_en   = 1'b0;
        load_sel  = 2'd0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        addr_r    = '0;
        addr_c    = '0;
        finished  = 1'b0;
        out_ready = 1'b0;

        for (int i = 0; i < S; i++) begin
            vecs[0].x[i]  = 8'(i+1);
            vecs[0].w0[i] = 8'(1);
            vecs[0].w1[i] = 8'(i+1);
            vecs[1].x[i]  = 8'(-128);
            vecs[1].w0[i] = 8'(127);
            vecs[1].w1[i] = 8'(-128);
            vecs[2].x[i]  = 8'(127);
            vecs[2].w0[i] = 8'(127);
            vecs[2].w1[i] = 8'(-1);
            vecs[3].x[i]  = (i % 2 == 0) ? 8'(i+1) : 8'(-(i+1));
            vecs[3].w0[i] = 8'(2);
            vecs[3].w1[i] = (i % 2 == 0) ? 8'(i+1) : 8'(-(i+1));
        end
        vecs[0].e0 = 36;      vecs[0].e1 = 204;
        vecs[1].e0 = -130048; vecs[1].e1 = 131072;
        vecs[2].e0 = 129032;  vecs[2].e1 = -1016;
        vecs[3].e0 = -8;      vecs[3].e1 = 204;

        #12;
        chk("rst_y0", y0, 0);
        chk("rst_y1", y1, 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sync_err", 32'(sync_err), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table of operand sets
        for (int v = 0; v < 4; v++) begin
            load_vec(vecs[v]);
            run_to_result(0, 0);
            expect_and_accept($sformatf("vec%0d", v), relu_exp(vecs[v].e0),
                              relu_exp(vecs[v].e1), 0);
        end
        chk("no_sync_err", 32'(sync_err), 0);

        // Stalled consumer, then an immediate second run
        load_vec(vecs[0]);
        run_to_result(0, 0);
        expect_and_accept("stall", 36, 204, 5);
        run_to_result(0, 0);
        expect_and_accept("after_stall", 36, 204, 0);

        // Asynchronous reset at step 4, then restart on the retained memories
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 4; k++) step_drive(k, 1'b0, 1'b0);
        chk("pre_reset_busy", 32'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_y0", y0, 0);
        chk("midrst_y1", y1, 0);
        #1;
        reset_n = 1'b1;
        run_to_result(0, 0);
        expect_and_accept("post_reset", 36, 204, 0);

        // Load attempt during a run is dropped
        run_to_result(0, 3);
        expect_and_accept("load_in_run", 36, 204, 0);
        run_to_result(0, 0);
        expect_and_accept("load_in_run_next", 36, 204, 0);

        // finished asserted out of lockstep sets a sticky error
        run_to_result(3, 0);
        chk("sync_err_set", 32'(sync_err), 1);
        expect_and_accept("sync_run", 36, 204, 0);
        run_to_result(0, 0);
        chk("sync_err_sticky", 32'(sync_err), 1);
        expect_and_accept("sync_next", 36, 204, 0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("sync_err_cleared", 32'(sync_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
